// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - opcode, ALU code, state and class definitions for mc_ctrl
package mc_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;

   localparam logic [2:0] ALU_ADD  = 3'b001;
   localparam logic [2:0] ALU_SUB  = 3'b011;
   localparam logic [2:0] ALU_ORI  = 3'b010;
   localparam logic [2:0] ALU_LW   = 3'b110;
   localparam logic [2:0] ALU_SW   = 3'b111;
   localparam logic [2:0] ALU_BEQ  = 3'b101;

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      EXE    = 4'd2,
      ALUWB  = 4'd3,
      MEMADR = 4'd4,
      MEMRD  = 4'd5,
      MEMWR  = 4'd6,
      LWWB   = 4'd7,
      BRANCH = 4'd8
   } state_t;

   typedef enum logic [2:0] {
      CLS_ADD = 3'd0,
      CLS_SUB = 3'd1,
      CLS_ORI = 3'd2,
      CLS_LW  = 3'd3,
      CLS_SW  = 3'd4,
      CLS_BEQ = 3'd5
   } cls_t;

endpackage

// File: rtl/mc_ctrl_dec.sv
// rtl/mc_ctrl_dec.sv - combinational op/funct to instruction class decoder
module mc_ctrl_dec
   import mc_ctrl_pkg::*;
(
   input  logic [5:0] op,
   input  logic [5:0] funct,
   output logic [2:0] cls,
   output logic       illegal
);

   always_comb begin
      cls     = CLS_ADD;
      illegal = 1'b0;
      case (op)
         OP_RTYPE: begin
            if (funct == FN_ADD)      cls = CLS_ADD;
            else if (funct == FN_SUB) cls = CLS_SUB;
            else                      illegal = 1'b1;
         end
         OP_ORI:  cls = CLS_ORI;
         OP_LW:   cls = CLS_LW;
         OP_SW:   cls = CLS_SW;
         OP_BEQ:  cls = CLS_BEQ;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle control FSM: fetch/decode/execute/memory/writeback
module mc_ctrl
   import mc_ctrl_pkg::*;
#(
   parameter bit OVF_TRAP = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       carrier,
   input  logic       dm_ready,
   output logic [2:0] ALUctrl,
   output logic       ALUSrc,
   output logic       ExtOp,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       NPCOp,
   output logic       PCWr,
   output logic       IRWr,
   output logic       RFWr,
   output logic       DMWr,
   output logic       DMRd,
   output logic       illegal,
   output logic       ovf,
   output logic [3:0] state
);

   // Kept as a raw 4-bit register so unused encodings are representable and recoverable
   logic [3:0] state_q, state_d;
   cls_t       cls_q;
   logic       ovf_q;
   logic [2:0] dec_cls;
   logic       dec_ill;
   logic       pcwr_d, irwr_d, rfwr_d, dmwr_d, dmrd_d, ill_d, ovf_d;

   mc_ctrl_dec u_dec (
      .op      (op),
      .funct   (funct),
      .cls     (dec_cls),
      .illegal (dec_ill)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FETCH;
         cls_q   <= CLS_ADD;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == DECODE) cls_q <= cls_t'(dec_cls);
         if (state_q == EXE)
            ovf_q <= carrier & ((cls_q == CLS_ADD) | (cls_q == CLS_SUB)) & OVF_TRAP;
      end
   end

   always_comb begin
      state_d  = FETCH;
      ALUctrl  = ALU_ADD;
      ALUSrc   = 1'b0;
      ExtOp    = 1'b0;
      RegDst   = 1'b0;
      MemtoReg = 1'b0;
      NPCOp    = 1'b0;
      pcwr_d   = 1'b0;
      irwr_d   = 1'b0;
      rfwr_d   = 1'b0;
      dmwr_d   = 1'b0;
      dmrd_d   = 1'b0;
      ill_d    = 1'b0;
      ovf_d    = 1'b0;
      case (state_q)
         FETCH: begin
            irwr_d  = 1'b1;
            pcwr_d  = 1'b1;
            state_d = DECODE;
         end
         DECODE: begin
            if (dec_ill) begin
               ill_d   = 1'b1;
               state_d = FETCH;
            end else begin
               case (cls_t'(dec_cls))
                  CLS_LW, CLS_SW: state_d = MEMADR;
                  CLS_BEQ:        state_d = BRANCH;
                  default:        state_d = EXE;
               endcase
            end
         end
         EXE: begin
            case (cls_q)
               CLS_SUB: ALUctrl = ALU_SUB;
               CLS_ORI: begin
                  ALUctrl = ALU_ORI;
                  ALUSrc  = 1'b1;
               end
               default: ALUctrl = ALU_ADD;
            endcase
            state_d = ALUWB;
         end
         ALUWB: begin
            RegDst  = (cls_q != CLS_ORI);
            rfwr_d  = ~ovf_q;
            ovf_d   = ovf_q;
            state_d = FETCH;
         end
         MEMADR: begin
            ALUctrl = (cls_q == CLS_SW) ? ALU_SW : ALU_LW;
            ALUSrc  = 1'b1;
            ExtOp   = 1'b1;
            state_d = (cls_q == CLS_SW) ? MEMWR : MEMRD;
         end
         MEMRD: begin
            // Address operands stay up for the whole read so the memory sees a stable address
            ALUctrl = ALU_LW;
            ALUSrc  = 1'b1;
            ExtOp   = 1'b1;
            dmrd_d  = 1'b1;
            state_d = dm_ready ? LWWB : MEMRD;
         end
         MEMWR: begin
            dmwr_d  = 1'b1;
            state_d = dm_ready ? FETCH : MEMWR;
         end
         LWWB: begin
            rfwr_d   = 1'b1;
            MemtoReg = 1'b1;
            state_d  = FETCH;
         end
         BRANCH: begin
            ALUctrl = ALU_BEQ;
            ExtOp   = 1'b1;
            NPCOp   = 1'b1;
            pcwr_d  = zero;
            state_d = FETCH;
         end
         default: state_d = FETCH;
      endcase
   end

   // Reset gates every side effect combinationally so the rst cycle itself writes nothing
   assign PCWr    = pcwr_d & ~rst;
   assign IRWr    = irwr_d & ~rst;
   assign RFWr    = rfwr_d & ~rst;
   assign DMWr    = dmwr_d & ~rst;
   assign DMRd    = dmrd_d & ~rst;
   assign illegal = ill_d  & ~rst;
   assign ovf     = ovf_d  & ~rst;
   assign state   = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - randomized self-checking bench for mc_ctrl against a per-instruction timeline model
module tb_mc_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] op, funct;
   logic       zero, carrier, dm_ready;
   logic [2:0] ALUctrl;
   logic       ALUSrc, ExtOp, RegDst, MemtoReg, NPCOp;
   logic       PCWr, IRWr, RFWr, DMWr, DMRd, illegal, ovf;
   logic [3:0] state;

   int n_tests = 0;
   int n_fail  = 0;

   localparam int B_SRC = 11, B_EXT = 10, B_DST = 9, B_M2R = 8, B_NPC = 7;
   localparam int B_PCW = 6, B_IRW = 5, B_RFW = 4, B_DMW = 3, B_DMR = 2;
   localparam int B_ILL = 1, B_OVF = 0;

   typedef struct {
      logic        z, c, r;
      logic [18:0] e, m;
      string       tag;
   } cyc_t;

   cyc_t q[$];

   mc_ctrl #(.OVF_TRAP(1'b1)) dut (
      .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .carrier(carrier),
      .dm_ready(dm_ready), .ALUctrl(ALUctrl), .ALUSrc(ALUSrc), .ExtOp(ExtOp),
      .RegDst(RegDst), .MemtoReg(MemtoReg), .NPCOp(NPCOp), .PCWr(PCWr), .IRWr(IRWr),
      .RFWr(RFWr), .DMWr(DMWr), .DMRd(DMRd), .illegal(illegal), .ovf(ovf), .state(state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [18:0] obs_vec();
      return {state, ALUctrl, ALUSrc, ExtOp, RegDst, MemtoReg, NPCOp,
              PCWr, IRWr, RFWr, DMWr, DMRd, illegal, ovf};
   endfunction

   // A cycle where state, ALUctrl and every enable/pulse are checked; muxes only when set with sb()
   function automatic cyc_t mk(input string tag, input int st, input logic [2:0] alu);
      cyc_t c;
      c.tag = tag;
      c.e   = {st[3:0], alu, 12'b0};
      c.m   = 19'h7F07F;
      c.z   = 1'($urandom);
      c.c   = 1'($urandom);
      c.r   = 1'($urandom);
      return c;
   endfunction

   function automatic cyc_t sb(input cyc_t c, input int b, input logic v);
      c.e[b] = v;
      c.m[b] = 1'b1;
      return c;
   endfunction

   // kind: 0 add, 1 sub, 2 ori, 3 lw, 4 sw, 5 beq, 6 random illegal, 7 op=111111
   task automatic run_instr(input int kind, input int nwait, input logic cx,
                            input logic zb, input int rst_at);
      cyc_t       c;
      logic [5:0] o, f;
      logic       ov;
      f = 6'($urandom);
      case (kind)
         0: begin o = 6'b000000; f = 6'b100000; end
         1: begin o = 6'b000000; f = 6'b100010; end
         2: o = 6'b001101;
         3: o = 6'b100011;
         4: o = 6'b101011;
         5: o = 6'b000100;
         7: o = 6'b111111;
         default: begin
            if ($urandom_range(0, 1) == 1) begin
               o = 6'b000000;
               do f = 6'($urandom); while (f == 6'b100000 || f == 6'b100010);
            end else begin
               do o = 6'($urandom);
               while (o == 6'b000000 || o == 6'b001101 || o == 6'b100011 ||
                      o == 6'b101011 || o == 6'b000100);
            end
         end
      endcase

      q.delete();
      c = sb(mk("fetch", 0, 3'b001), B_NPC, 1'b0);
      c.e[B_PCW] = 1'b1;
      c.e[B_IRW] = 1'b1;
      q.push_back(c);
      c = mk("decode", 1, 3'b001);
      c.e[B_ILL] = (kind >= 6);
      q.push_back(c);
      if (kind <= 2) begin
         c = mk("exe", 2, (kind == 0) ? 3'b001 : (kind == 1) ? 3'b011 : 3'b010);
         c.c = cx;
         c = sb(c, B_SRC, kind == 2);
         if (kind == 2) c = sb(c, B_EXT, 1'b0);
         q.push_back(c);
         ov = cx && (kind < 2);
         c = sb(sb(mk("aluwb", 3, 3'b001), B_DST, kind != 2), B_M2R, 1'b0);
         c.e[B_RFW] = !ov;
         c.e[B_OVF] = ov;
         q.push_back(c);
      end else if (kind == 3 || kind == 4) begin
         c = mk("memadr", 4, (kind == 3) ? 3'b110 : 3'b111);
         q.push_back(sb(sb(c, B_SRC, 1'b1), B_EXT, 1'b1));
         for (int i = 0; i <= nwait; i++) begin
            if (kind == 3) begin
               c = sb(sb(mk("memrd", 5, 3'b110), B_SRC, 1'b1), B_EXT, 1'b1);
               c.e[B_DMR] = 1'b1;
            end else begin
               c = mk("memwr", 6, 3'b001);
               c.m[14:12] = 3'b000;
               c.e[B_DMW] = 1'b1;
            end
            c.r = (i == nwait);
            q.push_back(c);
         end
         if (kind == 3) begin
            c = sb(sb(mk("lwwb", 7, 3'b001), B_DST, 1'b0), B_M2R, 1'b1);
            c.e[B_RFW] = 1'b1;
            q.push_back(c);
         end
      end else if (kind == 5) begin
         c = sb(sb(sb(mk("branch", 8, 3'b101), B_SRC, 1'b0), B_EXT, 1'b1), B_NPC, 1'b1);
         c.z = zb;
         c.e[B_PCW] = zb;
         q.push_back(c);
      end

      for (int i = 0; i < q.size(); i++) begin
         @(posedge clk);
         #1;
         if (i == 0) begin
            op    = o;
            funct = f;
         end
         zero     = q[i].z;
         carrier  = q[i].c;
         dm_ready = q[i].r;
         rst      = (i == rst_at);
         if (i == rst_at) q[i].e[6:0] = 7'b0;
         @(negedge clk);
         check(q[i].tag, 32'(obs_vec() & q[i].m), 32'(q[i].e & q[i].m));
         if (i == rst_at) break;
      end
   endtask

   initial begin
      rst = 1'b1; op = 6'b0; funct = 6'b0; zero = 1'b0; carrier = 1'b0; dm_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         check("rst_enables", 32'({PCWr, IRWr, RFWr, DMWr, DMRd, illegal, ovf}), 32'd0);
         check("rst_state", 32'(state), 32'd0);
      end

      run_instr(0, 0, 1'b0, 1'b0, -1);   // add
      run_instr(2, 0, 1'b1, 1'b0, -1);   // ori, carrier ignored
      run_instr(3, 2, 1'b0, 1'b0, -1);   // lw with two wait cycles
      run_instr(4, 0, 1'b0, 1'b0, -1);   // sw
      run_instr(5, 0, 1'b0, 1'b1, -1);   // beq taken
      run_instr(5, 0, 1'b0, 1'b0, -1);   // beq not taken
      run_instr(1, 0, 1'b1, 1'b0, -1);   // sub overflow trap
      run_instr(7, 0, 1'b0, 1'b0, -1);   // op=111111
      run_instr(4, 2, 1'b0, 1'b0, 4);    // reset during MEMWR
      run_instr(0, 0, 1'b1, 1'b0, -1);   // add overflow after reset

      for (int n = 0; n < 400; n++) begin
         int k, rs;
         k  = $urandom_range(0, 6);
         rs = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : -1;
         run_instr(k, $urandom_range(0, 3), 1'($urandom), 1'($urandom), rs);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
